// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access owner and the
// latched request record.
package dmem_arb_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, debug and memory-side signals around the arbiter.
// The arbiter connects through 'slave'; requesters and memory use 'master'.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_stall_o;

  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              dbg_ack_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_rdata_o, dbg_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_rdata_o, dbg_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Shares a fixed-latency single-ported data memory between the CPU MEM stage
// and a debug/DMA port; CPU has priority, bounded by a starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t            state;
  owner_t            owner;
  logic [3:0]        cnt;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic any_req;
  logic dbg_wins;
  req_t sel_req;

  // Debug takes the slot when it is alone or the CPU has used up its quota.
  always_comb begin
    any_req  = bus.cpu_req_i | bus.dbg_req_i;
    dbg_wins = bus.dbg_req_i & (~bus.cpu_req_i | (starve_cnt == STARVE_MAX));
    sel_req  = '{we:    bus.cpu_we_i,
                 addr:  REQ_ADDR_W'(bus.cpu_addr_i),
                 wdata: REQ_DATA_W'(bus.cpu_wdata_i)};
    if (dbg_wins) begin
      sel_req = '{we:    bus.dbg_we_i,
                  addr:  REQ_ADDR_W'(bus.dbg_addr_i),
                  wdata: REQ_DATA_W'(bus.dbg_wdata_i)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      cnt        <= '0;
      starve_cnt <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ISSUE;
            owner     <= dbg_wins ? OWN_DBG : OWN_CPU;
            mem_we    <= sel_req.we;
            mem_addr  <= ADDR_W'(sel_req.addr);
            mem_wdata <= DATA_W'(sel_req.wdata);
            if (dbg_wins || !bus.dbg_req_i) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ISSUE: begin
          cnt   <= LAT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (owner == OWN_CPU) begin
              cpu_rdata <= bus.mem_rdata_i;
            end else begin
              dbg_rdata <= bus.mem_rdata_i;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is released only in the CPU's own completion cycle.
  assign bus.cpu_stall_o = ~rst_i & bus.cpu_req_i & ~((state == RESP) && (owner == OWN_CPU));
  assign bus.dbg_ack_o   = ~rst_i & (state == RESP) & (owner == OWN_DBG);
  assign bus.cpu_rdata_o = cpu_rdata;
  assign bus.dbg_rdata_o = dbg_rdata;
  assign bus.mem_en_o    = (state == ISSUE);
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 16-word fixed-latency
// memory model that only presents valid read data in cycle issue+MEM_LAT.
module tb_dmem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_LIM = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  logic [31:0] mem [0:15];
  int          lat_cnt;
  logic [3:0]  raddr;

  // Word 0 = 5, other words = 0x1000_0000 + index; reloaded on every reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= 0;
      raddr   <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[0] <= 32'd5;
    end else if (bus.mem_en_o) begin
      lat_cnt <= 1;
      raddr   <= bus.mem_addr_o[5:2];
      if (bus.mem_we_o) mem[bus.mem_addr_o[5:2]] <= bus.mem_wdata_o;
    end else if (lat_cnt != 0 && lat_cnt < 15) begin
      lat_cnt <= lat_cnt + 1;
    end
  end

  assign bus.mem_rdata_i = (lat_cnt == MEM_LAT) ? mem[raddr] : 32'hDEAD_BEEF;

  task automatic clear_inputs();
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    bus.dbg_req_i   = 1'b0;
    bus.dbg_we_i    = 1'b0;
    bus.dbg_addr_i  = '0;
    bus.dbg_wdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one CPU access from an IDLE cycle until the stall drops, then releases the request.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output int stall_n, output int en_c,
                            output logic obs_we, output logic [31:0] obs_addr,
                            output logic [31:0] obs_wdata);
    bit done = 0;
    rd = '0; stall_n = 0; en_c = -1; obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_en_o) begin
        en_c      = c;
        obs_we    = bus.mem_we_o;
        obs_addr  = bus.mem_addr_o;
        obs_wdata = bus.mem_wdata_o;
      end
      if (!bus.cpu_stall_o) begin
        rd   = bus.cpu_rdata_o;
        done = 1;
        break;
      end
      stall_n++;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL cpu_access_timeout: stall still 1 after %0d cycles, required release", stall_n);
    end
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.cpu_req_i  = 1'b1;
    bus.dbg_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h40;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (bus.cpu_stall_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_stall: got %b want 0", bus.cpu_stall_o); end
    n_cmp++; if (bus.dbg_ack_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ack: got %b want 0", bus.dbg_ack_o); end
    n_cmp++; if (bus.mem_en_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mem_en: got %b want 0", bus.mem_en_o); end
    n_cmp++; if (bus.mem_we_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mem_we: got %b want 0", bus.mem_we_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_wdata_o !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata_o); end
    n_cmp++; if (bus.cpu_rdata_o !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_cpu_rdata: got %h want 0", bus.cpu_rdata_o); end
    n_cmp++; if (bus.dbg_rdata_o !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_dbg_rdata: got %h want 0", bus.dbg_rdata_o); end
    clear_inputs();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    do_reset();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h0;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.mem_en_o !== (c == 1)) begin
        n_bad++; $display("[TB] FAIL cpu_read_mem_en c%0d: got %b want %b", c, bus.mem_en_o, (c == 1));
      end
      n_cmp++;
      if (bus.cpu_stall_o !== (c < 4)) begin
        n_bad++; $display("[TB] FAIL cpu_read_stall c%0d: got %b want %b", c, bus.cpu_stall_o, (c < 4));
      end
      if (c == 4) begin
        n_cmp++;
        if (bus.cpu_rdata_o !== 32'd5) begin
          n_bad++; $display("[TB] FAIL cpu_read_data: got %h want 00000005", bus.cpu_rdata_o);
        end
      end
      @(posedge clk); #1;
      if (c == 4) bus.cpu_req_i = 1'b0;
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, oa, owd;
    logic        ow;
    int          sn, ec;
    do_reset();
    cpu_access(1'b1, 32'h8, 32'hA5, rd, sn, ec, ow, oa, owd);
    n_cmp++; if (sn !== 4) begin n_bad++; $display("[TB] FAIL write_stall_cycles: got %0d want 4", sn); end
    n_cmp++; if (ec !== 1) begin n_bad++; $display("[TB] FAIL write_issue_cycle: got %0d want 1", ec); end
    n_cmp++; if (ow !== 1'b1) begin n_bad++; $display("[TB] FAIL write_mem_we: got %b want 1", ow); end
    n_cmp++; if (oa !== 32'h8) begin n_bad++; $display("[TB] FAIL write_mem_addr: got %h want 00000008", oa); end
    n_cmp++; if (owd !== 32'hA5) begin n_bad++; $display("[TB] FAIL write_mem_wdata: got %h want 000000a5", owd); end
    n_cmp++; if (mem[2] !== 32'hA5) begin n_bad++; $display("[TB] FAIL write_mem_word2: got %h want 000000a5", mem[2]); end
    cpu_access(1'b0, 32'h8, 32'h0, rd, sn, ec, ow, oa, owd);
    n_cmp++; if (sn !== 4) begin n_bad++; $display("[TB] FAIL readback_stall_cycles: got %0d want 4", sn); end
    n_cmp++; if (ow !== 1'b0) begin n_bad++; $display("[TB] FAIL readback_mem_we: got %b want 0", ow); end
    n_cmp++; if (rd !== 32'hA5) begin n_bad++; $display("[TB] FAIL readback_data: got %h want 000000a5", rd); end
  endtask

  task automatic test_dbg_alone();
    bit stall_seen = 0;
    do_reset();
    bus.dbg_req_i  = 1'b1;
    bus.dbg_addr_i = 32'h4;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (bus.cpu_stall_o !== 1'b0) stall_seen = 1;
      n_cmp++;
      if (bus.dbg_ack_o !== (c == 4)) begin
        n_bad++; $display("[TB] FAIL dbg_ack c%0d: got %b want %b", c, bus.dbg_ack_o, (c == 4));
      end
      if (c == 1) begin
        n_cmp++;
        if (bus.mem_addr_o !== 32'h4) begin
          n_bad++; $display("[TB] FAIL dbg_mem_addr: got %h want 00000004", bus.mem_addr_o);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (bus.dbg_rdata_o !== 32'h1000_0001) begin
          n_bad++; $display("[TB] FAIL dbg_rdata: got %h want 10000001", bus.dbg_rdata_o);
        end
      end
      @(posedge clk); #1;
      if (c == 4) bus.dbg_req_i = 1'b0;
    end
    n_cmp++; if (stall_seen) begin n_bad++; $display("[TB] FAIL dbg_cpu_stall: got 1 want 0"); end
  endtask

  // CPU at 0x10, debug at 0x20, both held: grants C,C,C,C,D repeating.
  task automatic test_starvation();
    int  g = 0;
    logic is_dbg;
    logic [3:0] exp_sc;
    do_reset();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h10;
    bus.dbg_req_i  = 1'b1;
    bus.dbg_addr_i = 32'h20;
    for (int c = 0; c < 80 && g < 10; c++) begin
      @(negedge clk);
      if (bus.mem_en_o) begin
        is_dbg = (bus.mem_addr_o == 32'h20);
        exp_sc = (g % 5 == 4) ? 4'd0 : 4'((g % 5) + 1);
        n_cmp++;
        if (is_dbg !== (g % 5 == 4)) begin
          n_bad++; $display("[TB] FAIL starve_grant g%0d: got dbg=%b want dbg=%b", g, is_dbg, (g % 5 == 4));
        end
        n_cmp++;
        if (dut.starve_cnt !== exp_sc) begin
          n_bad++; $display("[TB] FAIL starve_cnt g%0d: got %0d want %0d", g, dut.starve_cnt, exp_sc);
        end
        g++;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (g !== 10) begin n_bad++; $display("[TB] FAIL starve_grant_count: got %0d want 10", g); end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    int cpu_c = -1, dbg_c = -1, dbg_en_c = -1;
    do_reset();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h0;
    bus.dbg_req_i  = 1'b1;
    bus.dbg_addr_i = 32'h4;
    for (int c = 0; c < 20 && (cpu_c < 0 || dbg_c < 0); c++) begin
      @(negedge clk);
      if (bus.mem_en_o && bus.mem_addr_o == 32'h4) dbg_en_c = c;
      if (bus.cpu_req_i && !bus.cpu_stall_o && cpu_c < 0) begin
        cpu_c = c;
        n_cmp++;
        if (bus.cpu_rdata_o !== 32'd5) begin
          n_bad++; $display("[TB] FAIL sim_cpu_rdata: got %h want 00000005", bus.cpu_rdata_o);
        end
      end
      if (bus.dbg_ack_o && dbg_c < 0) begin
        dbg_c = c;
        n_cmp++;
        if (bus.dbg_rdata_o !== 32'h1000_0001) begin
          n_bad++; $display("[TB] FAIL sim_dbg_rdata: got %h want 10000001", bus.dbg_rdata_o);
        end
      end
      @(posedge clk); #1;
      if (c == cpu_c) bus.cpu_req_i = 1'b0;
      if (c == dbg_c) bus.dbg_req_i = 1'b0;
    end
    n_cmp++; if (cpu_c !== 4) begin n_bad++; $display("[TB] FAIL sim_cpu_resp_cycle: got %0d want 4", cpu_c); end
    n_cmp++; if (dbg_en_c !== 6) begin n_bad++; $display("[TB] FAIL sim_dbg_issue_cycle: got %0d want 6", dbg_en_c); end
    n_cmp++; if (dbg_c !== 9) begin n_bad++; $display("[TB] FAIL sim_dbg_ack_cycle: got %0d want 9", dbg_c); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, oa, owd;
    logic        ow;
    int          sn, ec;
    do_reset();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.cpu_stall_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_stall: got %b want 0", bus.cpu_stall_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_bad++; $display("[TB] FAIL midrst_mem_addr: got %h want 0", bus.mem_addr_o); end
    n_cmp++; if (bus.cpu_rdata_o !== 32'h0) begin n_bad++; $display("[TB] FAIL midrst_cpu_rdata: got %h want 0", bus.cpu_rdata_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (bus.mem_en_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_mem_en: got %b want 0", bus.mem_en_o); end
    @(posedge clk); #1 rst = 1'b0;
    cpu_access(1'b0, 32'h4, 32'h0, rd, sn, ec, ow, oa, owd);
    n_cmp++; if (sn !== 4) begin n_bad++; $display("[TB] FAIL midrst_restart_stall: got %0d want 4", sn); end
    n_cmp++; if (ec !== 1) begin n_bad++; $display("[TB] FAIL midrst_restart_issue: got %0d want 1", ec); end
    n_cmp++; if (rd !== 32'h1000_0001) begin n_bad++; $display("[TB] FAIL midrst_restart_data: got %h want 10000001", rd); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    test_reset();
    test_cpu_read();
    test_write_read();
    test_dbg_alone();
    test_starvation();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between the CPU's MEM stage and a debug/DMA requester. It sequences each access against a fixed-latency memory and drives a stall back into the pipeline while the CPU access is outstanding. The CPU has priority. A starvation guard guarantees the debug port a grant after a bounded number of CPU wins. It sits between the MEM stage and `Data_Memory`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, memory read latency in cycles from the issue cycle (legal 1..15)
- `STARVE_LIM`, 4, consecutive CPU grants allowed while debug is pending (legal 1..15)

Ports:
- `clk_i` in 1: single clock; all state on rising edge
- `rst_i` in 1: asynchronous, active-high reset
- `cpu_req_i` in 1: MEM-stage access request; held stable while stalled
- `cpu_we_i` in 1: 1 = write
- `cpu_addr_i` in `ADDR_W`
- `cpu_wdata_i` in `DATA_W`
- `cpu_rdata_o` out `DATA_W`: read data, valid in the CPU RESP cycle, held until the next CPU completion
- `cpu_stall_o` out 1: freeze pipeline
- `dbg_req_i` in 1: debug request; held stable until `dbg_ack_o`
- `dbg_we_i` in 1
- `dbg_addr_i` in `ADDR_W`
- `dbg_wdata_i` in `DATA_W`
- `dbg_rdata_o` out `DATA_W`: same hold rule as `cpu_rdata_o`
- `dbg_ack_o` out 1: one-cycle completion pulse
- `mem_en_o` out 1: one-cycle command strobe
- `mem_we_o` out 1
- `mem_addr_o` out `ADDR_W`
- `mem_wdata_o` out `DATA_W`
- `mem_rdata_i` in `DATA_W`: valid in cycle issue+`MEM_LAT`

## Operation
- FSM states:
  - IDLE: arbitrate. Go to ISSUE if any request is present, latching the owner and the request fields.
  - ISSUE: `mem_en_o`=1 for exactly one cycle. Load `cnt`=`MEM_LAT`-1. Go to WAIT.
  - WAIT: decrement `cnt` each cycle. When `cnt`==0, capture `mem_rdata_i` into the owner's rdata register and go to RESP.
  - RESP: owner completes. Return to IDLE.
- Writes follow the same sequence. The rdata register is still updated on a write, with don't-care contents; the bench must not check it.
- Arbitration in IDLE:
  - CPU wins by default.
  - Debug wins if it is the only requester, or if `starve_cnt`==`STARVE_LIM`.
- `starve_cnt` (4 bit):
  - Increments on a CPU grant while `dbg_req_i`=1.
  - Clears on a debug grant, or on a CPU grant while `dbg_req_i`=0.
  - Saturates at `STARVE_LIM`.
- `cpu_stall_o` is combinational: `cpu_req_i` AND NOT (state==RESP AND owner==CPU).
- `dbg_ack_o` = (state==RESP AND owner==DBG).
- `mem_we_o`, `mem_addr_o`, `mem_wdata_o` are registered copies of the granted request. They hold from ISSUE through RESP and are zero in IDLE.
- Reset: asynchronous, to IDLE. Clears `cnt`, `starve_cnt`, owner, both rdata registers and all `mem_*` outputs. `cpu_stall_o` and `dbg_ack_o` are forced to 0 while `rst_i`=1.
- Reset mid-access abandons the access. A write already strobed may have landed in memory; no ack or completion is produced.

## Timing
- A request seen in IDLE cycle 0 produces:
  - ISSUE in cycle 1
  - WAIT in cycles 2..1+`MEM_LAT`
  - RESP in cycle 2+`MEM_LAT`
- CPU stall duration is `MEM_LAT`+2 cycles (`MEM_LAT`=2 gives 4 stall cycles, then 1 free cycle).
- Throughput: one access per `MEM_LAT`+3 cycles. RESP always returns to IDLE; there is no back-to-back issue.
- Simultaneous requests in IDLE resolve in the same cycle. The loser's request persists and is granted at the next IDLE.
- A request arriving during ISSUE, WAIT or RESP is not sampled until IDLE.
- A CPU request with no grant yet keeps `cpu_stall_o`=1. The pipeline stays frozen through a debug access.

## Structure
- Package `dmem_arb_pkg`:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_CPU, OWN_DBG}
  - request struct {we, addr, wdata}
- Single module; no sub-module. Counter and arbitration are small enough to stay inline.

## Test plan
- CPU read, `MEM_LAT`=2, memory word 0 = 5, `cpu_req_i` held at addr 0 → `mem_en_o` pulses in cycle 1; `cpu_stall_o`=1 for cycles 0–3; cycle 4 `cpu_stall_o`=0 and `cpu_rdata_o`=5.
- CPU write addr 0x8, data 0xA5, then read 0x8 → memory word 2 = 0xA5; read returns 0xA5 after `MEM_LAT`+2 stall cycles.
- Debug alone: read 0x4 → `dbg_ack_o` one-cycle pulse in cycle 4, `dbg_rdata_o` = memory word 1; `cpu_stall_o` stays 0 throughout.
- Both requesters continuous, `STARVE_LIM`=4 → grant sequence CPU, CPU, CPU, CPU, DBG, then repeating; `starve_cnt` is 0 after the DBG grant.
- Simultaneous single requests → CPU completes first; debug is issued at the following IDLE; `dbg_ack_o` is 5 cycles after the CPU RESP.
- `rst_i` pulsed during WAIT of a CPU read → all outputs 0 immediately; no RESP; after release with `cpu_req_i` still high, the access restarts from IDLE with full latency.
